imm_gen_pipe: RTL

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 124 ++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32 immediate decoder behind a 2-entry valid/ready skid buffer.
// Ports: clk, rst_n (sync, active-low), flush; in_valid/in_ready/inst/in_tag (input side);
// out_valid/out_ready/imm/fmt/illegal/out_tag (output side); illegal_cnt (saturating count).
// Optional feature: define IMM_GEN_CSR_IMM_EN to decode CSR immediate forms as fmt Z.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      illegal_cnt
);
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } res_t;

    localparam res_t RST_RES = '{imm: '0, fmt: 3'd7, ill: 1'b0, tag: '0};

    res_t dec, out_r, skid_r;
    logic out_v, skid_v, rdy;
    logic acc, pop;

    assign acc = in_valid && rdy;
    assign pop = out_v && out_ready;

    // Sized casts of signed operands sign-extend to XLEN without zero-width replications.
    always_comb begin
        dec.imm = '0;
        dec.fmt = 3'd7;
        dec.ill = 1'b1;
        dec.tag = in_tag;
        case (inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                dec.imm = XLEN'($signed(inst[31:20]));
                dec.fmt = 3'd1;
                dec.ill = 1'b0;
            end
            7'b0100011: begin
                dec.imm = XLEN'($signed({inst[31:25], inst[11:7]}));
                dec.fmt = 3'd2;
                dec.ill = 1'b0;
            end
            7'b1100011: begin
                dec.imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
                dec.fmt = 3'd3;
                dec.ill = 1'b0;
            end
            7'b0110111, 7'b0010111: begin
                dec.imm = XLEN'($signed({inst[31:12], 12'b0}));
                dec.fmt = 3'd4;
                dec.ill = 1'b0;
            end
            7'b1101111: begin
                dec.imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
                dec.fmt = 3'd5;
                dec.ill = 1'b0;
            end
            7'b0110011: begin
                dec.fmt = 3'd0;
                dec.ill = 1'b0;
            end
`ifdef IMM_GEN_CSR_IMM_EN
            7'b1110011: begin
                if (inst[14]) begin
                    dec.imm = XLEN'(inst[19:15]);
                    dec.fmt = 3'd6;
                    dec.ill = 1'b0;
                end
            end
`endif
            default: ;
        endcase
    end

    // rdy is the registered copy of !skid_v, so out_ready never reaches in_ready combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_v       <= 1'b0;
            skid_v      <= 1'b0;
            rdy         <= 1'b0;
            out_r       <= RST_RES;
            skid_r      <= RST_RES;
            illegal_cnt <= '0;
        end else begin
            if (acc && !flush && dec.ill && illegal_cnt != 16'hFFFF)
                illegal_cnt <= illegal_cnt + 16'd1;
            if (flush) begin
                out_v  <= 1'b0;
                skid_v <= 1'b0;
                rdy    <= 1'b1;
            end else if (!out_v || pop) begin
                out_v  <= skid_v || acc;
                out_r  <= skid_v ? skid_r : (acc ? dec : out_r);
                skid_v <= 1'b0;
                rdy    <= 1'b1;
            end else if (acc) begin
                skid_r <= dec;
                skid_v <= 1'b1;
                rdy    <= 1'b0;
            end
        end
    end

    assign in_ready  = rdy;
    assign out_valid = out_v;
    assign imm       = out_r.imm;
    assign fmt       = out_r.fmt;
    assign illegal   = out_r.ill;
    assign out_tag   = out_r.tag;
endmodule
